pe_out_collector: RTL and testbench
===================================

# pe_out_collector

Downstream stage of the dual complex-MAC PE pair. It takes the two skewed 64-bit result lanes, where lane 1 lags lane 0 by one cycle. It realigns each lane-0 result with its lane-1 partner and saturates all four components to OUT_W bits. Aligned pairs are buffered in a show-ahead FIFO and presented to the writeback/DMA consumer over a valid/ready handshake, with sticky error flags and a saturation counter.

## Interface
- WORD_LEN, 24: PE operand width. Informational only; results arrive sign-extended in 64 bits.
- OUT_W, 32: output component width, signed. Legal range 2..63.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- din_R_0, din_I_0  in  64  lane-0 result, signed.
- valid_in_0  in  1  lane-0 result valid.
- din_R_1, din_I_1  in  64  lane-1 result, signed. Arrives one cycle after its lane-0 partner.
- valid_in_1  in  1  lane-1 result valid.
- clr_err  in  1  synchronous clear of skew_err, ovf_err and sat_cnt.
- dout_R_0, dout_I_0, dout_R_1, dout_I_1  out  OUT_W each  head-of-FIFO pair, signed. Driven to 0 when the FIFO is empty.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts the head entry.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- skew_err  out  1  sticky: an unpaired lane result was seen.
- ovf_err  out  1  sticky: a pair was dropped because the FIFO was full.
- sat_cnt  out  16  number of components clipped. Stops at 0xFFFF.

## Operation
- **Deskew register:** each cycle, d0 ← {din_R_0, din_I_0} and v0d ← valid_in_0. There is no enable; the register is always loaded.
- **Pair formation (cycle c):**
  - pair_ok = v0d & valid_in_1.
  - The pair is {d0, din_*_1}.
- **Skew error:** v0d ^ valid_in_1 sets skew_err. The lone half is discarded and nothing is pushed.
- **Saturation per component:**
  - x > 2^(OUT_W-1)-1 clips to the max value.
  - x < -2^(OUT_W-1) clips to the min value.
  - Otherwise the value is truncated to its low OUT_W bits, which is lossless in this range.
- **Saturation count:** sat_cnt adds the number of components clipped in a pushed pair (0–4). The counter stops at 0xFFFF. Clipped components of dropped pairs are not counted.
- **FIFO:**
  - push = pair_ok & (!full | pop).
  - pop = dout_valid & dout_ready.
  - Simultaneous push and pop when full is legal: the pair is accepted and level is unchanged.
  - Simultaneous push and pop when empty is not possible, because data is show-ahead from registered memory and dout_valid is 0.
- **Overflow:** pair_ok & full & !pop sets ovf_err. The pair is dropped and the FIFO is unchanged.
- **Pointers:** pointers wrap modulo FIFO_DEPTH. The extra MSB distinguishes full from empty.
- **clr_err:** clears skew_err, ovf_err and sat_cnt. If an error event occurs in the same cycle, the event wins and the flag is set. sat_cnt loads the increment of that cycle.
- **Reset:**
  - Outputs: dout_* = 0, dout_valid = 0, level = 0, skew_err = 0, ovf_err = 0, sat_cnt = 0.
  - Internal: v0d = 0; d0 and pointers cleared.
  - Reset mid-stream discards all buffered pairs. A lane-1 result arriving in the first cycle after reset release is a skew_err.

## Timing
- **Latency:** valid_in_0 in cycle t and valid_in_1 in t+1 push at the end of t+1. dout_valid rises in t+2 if the FIFO was empty.
- **Back-to-back:** consecutive lane-0 results every cycle pair correctly. This gives a sustained throughput of one pair per cycle while dout_ready = 1.
- **Handshake:**
  - dout_* is stable while dout_valid & !dout_ready.
  - dout_valid does not depend combinationally on dout_ready.
- **Flag timing:** level, errors and sat_cnt update at the same edge as the push or pop that affects them.

## Test plan
- **Basic pair:** R0=5, I0=-3 at t; R1=7, I1=0 at t+1; dout_ready=1.
  - Expect at t+2: dout_valid=1, dout=(5,-3,7,0).
  - Expect at t+3: dout_valid=0, level=0.
- **Saturation:** R0=0x0000_0001_0000_0000, I0=-2^40, R1=2^31-1, I1=-2^31, OUT_W=32.
  - Expect dout=(0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0x80000000).
  - Expect sat_cnt=2.
- **Skew error:**
  - valid_in_0 pulse with no valid_in_1 at t+1 → skew_err=1 at t+2 and nothing pushed.
  - Then clr_err=1 for one cycle → skew_err=0.
- **Full/overflow:** dout_ready=0; 5 consecutive aligned pairs with values 1..5.
  - Expect level=4 and ovf_err=1; pair 5 lost.
  - Then dout_ready=1 → pops 1,2,3,4 in order, then dout_valid=0.
- **Full with simultaneous pop:** FIFO full, dout_ready=1, new pair 9 arriving.
  - Expect level stays 4 and ovf_err stays 0.
  - Pair 9 emerges after the 4 buffered pairs.
- **Reset mid-operation:** 3 pairs buffered; rst=1 for one cycle.
  - Expect the next cycle: dout_valid=0, level=0, dout_*=0, all flags 0.

Source files
------------

// File: rtl/pe_out_if.sv
// rtl/pe_out_if.sv - skewed PE result lanes in, aligned saturated pair out
interface pe_out_if #(
  parameter int OUT_W = 32
);
  logic signed [63:0] din_R_0;
  logic signed [63:0] din_I_0;
  logic               valid_in_0;
  logic signed [63:0] din_R_1;
  logic signed [63:0] din_I_1;
  logic               valid_in_1;
  logic [OUT_W-1:0]   dout_R_0;
  logic [OUT_W-1:0]   dout_I_0;
  logic [OUT_W-1:0]   dout_R_1;
  logic [OUT_W-1:0]   dout_I_1;
  logic               dout_valid;
  logic               dout_ready;

  // Collector side: consumes PE lanes, sources the output stream.
  modport slave (
    input  din_R_0, din_I_0, valid_in_0,
    input  din_R_1, din_I_1, valid_in_1,
    input  dout_ready,
    output dout_R_0, dout_I_0, dout_R_1, dout_I_1, dout_valid
  );

  // Environment side: drives PE lanes, sinks the output stream.
  modport master (
    output din_R_0, din_I_0, valid_in_0,
    output din_R_1, din_I_1, valid_in_1,
    output dout_ready,
    input  dout_R_0, dout_I_0, dout_R_1, dout_I_1, dout_valid
  );
endinterface

// File: rtl/pe_out_collector.sv
// rtl/pe_out_collector.sv - deskew, saturate and buffer dual-lane PE results
module pe_out_collector #(
  parameter int WORD_LEN   = 24,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  pe_out_if.slave       bus,
  input  logic          clr_err,
  output logic [LW-1:0] level,
  output logic          skew_err,
  output logic          ovf_err,
  output logic [15:0]   sat_cnt
);

  // Elaboration-time parameter sanity.
  if (WORD_LEN < 1 || WORD_LEN > 64) begin : g_bad_word_len
    $error("WORD_LEN must be within 1..64");
  end
  if (OUT_W < 2 || OUT_W > 63) begin : g_bad_out_w
    $error("OUT_W must be within 2..63");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));
  localparam int                 EW      = 4 * OUT_W;

  function automatic logic is_clip(input logic signed [63:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  // In-range values are already sign-extended, so the low bits are exact.
  function automatic logic [OUT_W-1:0] sat_val(input logic signed [63:0] x);
    if (x > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  logic signed [63:0] d0_r_q, d0_i_q;
  logic               v0d_q;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               skew_err_q, ovf_err_q;
  logic [15:0]        sat_cnt_q;

  logic               pair_ok, skew_evt, full, empty, push, pop, ovf_evt;
  logic [AW:0]        level_w;
  logic [EW-1:0]      entry_d;
  logic [2:0]         clip_n, sat_inc;
  logic [16:0]        sat_sum;
  logic               skew_err_d, ovf_err_d;
  logic [15:0]        sat_cnt_d;
  logic [EW-1:0]      head;

  // Pair formation, FIFO control and flag next-state.
  always_comb begin
    pair_ok  = v0d_q & bus.valid_in_1;
    skew_evt = v0d_q ^ bus.valid_in_1;
    level_w  = wr_ptr_q - rd_ptr_q;
    full     = (level_w == LW'(FIFO_DEPTH));
    empty    = (wr_ptr_q == rd_ptr_q);
    pop      = !empty & bus.dout_ready;
    push     = pair_ok & (!full | pop);
    ovf_evt  = pair_ok & full & !pop;

    entry_d  = {sat_val(d0_r_q), sat_val(d0_i_q),
                sat_val(bus.din_R_1), sat_val(bus.din_I_1)};
    clip_n   = {2'b00, is_clip(d0_r_q)} + {2'b00, is_clip(d0_i_q)}
             + {2'b00, is_clip(bus.din_R_1)} + {2'b00, is_clip(bus.din_I_1)};
    sat_inc  = push ? clip_n : 3'd0;
    sat_sum  = {1'b0, sat_cnt_q} + {14'd0, sat_inc};

    // A same-cycle event overrides the clear.
    skew_err_d = skew_evt | (skew_err_q & !clr_err);
    ovf_err_d  = ovf_evt  | (ovf_err_q  & !clr_err);
    if (clr_err)         sat_cnt_d = {13'd0, sat_inc};
    else if (sat_sum[16]) sat_cnt_d = 16'hFFFF;
    else                 sat_cnt_d = sat_sum[15:0];
  end

  // Deskew register, pointers and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_r_q     <= '0;
      d0_i_q     <= '0;
      v0d_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skew_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      d0_r_q     <= bus.din_R_0;
      d0_i_q     <= bus.din_I_0;
      v0d_q      <= bus.valid_in_0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      skew_err_q <= skew_err_d;
      ovf_err_q  <= ovf_err_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // Entry storage; stale contents are masked by the empty check.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

  assign head           = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.dout_R_0   = head[4*OUT_W-1:3*OUT_W];
  assign bus.dout_I_0   = head[3*OUT_W-1:2*OUT_W];
  assign bus.dout_R_1   = head[2*OUT_W-1:OUT_W];
  assign bus.dout_I_1   = head[OUT_W-1:0];
  assign bus.dout_valid = !empty;
  assign level          = level_w;
  assign skew_err       = skew_err_q;
  assign ovf_err        = ovf_err_q;
  assign sat_cnt        = sat_cnt_q;

endmodule

// File: tb/tb_pe_out_collector.sv
// tb/tb_pe_out_collector.sv - directed self-checking bench for pe_out_collector
module tb_pe_out_collector;

  localparam logic [63:0] HUGE = 64'h4000_0000_0000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic [2:0] level;
  logic       skew_err, ovf_err;
  logic [15:0] sat_cnt;
  int         checks = 0;
  int         errors = 0;

  pe_out_if #(.OUT_W(32)) bus ();

  pe_out_collector #(.WORD_LEN(24), .OUT_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_err(clr_err),
    .level(level), .skew_err(skew_err), .ovf_err(ovf_err), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic v0, input logic [63:0] a0,
                       input logic v1, input logic [63:0] a1);
    bus.valid_in_0 = v0;
    bus.din_R_0    = a0;
    bus.din_I_0    = a0;
    bus.valid_in_1 = v1;
    bus.din_R_1    = a1;
    bus.din_I_1    = a1;
  endtask

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    bus.dout_ready = 1'b0;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    tick;
    tick;
    check("rst_valid", {63'd0, bus.dout_valid}, 64'd0);
    check("rst_level", {61'd0, level}, 64'd0);
    check("rst_skew", {63'd0, skew_err}, 64'd0);
    check("rst_ovf", {63'd0, ovf_err}, 64'd0);
    check("rst_sat", {48'd0, sat_cnt}, 64'd0);
    check("rst_dout", {32'd0, bus.dout_R_0}, 64'd0);
    rst = 1'b0;

    // Basic pair
    bus.dout_ready = 1'b1;
    bus.valid_in_0 = 1'b1; bus.din_R_0 = 64'sd5; bus.din_I_0 = -64'sd3;
    tick;
    bus.valid_in_0 = 1'b0;
    bus.valid_in_1 = 1'b1; bus.din_R_1 = 64'sd7; bus.din_I_1 = 64'sd0;
    tick;
    bus.valid_in_1 = 1'b0;
    check("basic_valid", {63'd0, bus.dout_valid}, 64'd1);
    check("basic_r0", {32'd0, bus.dout_R_0}, 64'h5);
    check("basic_i0", {32'd0, bus.dout_I_0}, 64'hFFFF_FFFD);
    check("basic_r1", {32'd0, bus.dout_R_1}, 64'h7);
    check("basic_i1", {32'd0, bus.dout_I_1}, 64'h0);
    check("basic_level", {61'd0, level}, 64'd1);
    tick;
    check("basic_drain_valid", {63'd0, bus.dout_valid}, 64'd0);
    check("basic_drain_level", {61'd0, level}, 64'd0);
    check("basic_skew", {63'd0, skew_err}, 64'd0);

    // Saturation
    bus.dout_ready = 1'b0;
    bus.valid_in_0 = 1'b1;
    bus.din_R_0 = 64'h0000_0001_0000_0000;
    bus.din_I_0 = -(64'sd1 <<< 40);
    tick;
    bus.valid_in_0 = 1'b0;
    bus.valid_in_1 = 1'b1;
    bus.din_R_1 = 64'sd2147483647;
    bus.din_I_1 = -64'sd2147483648;
    tick;
    bus.valid_in_1 = 1'b0;
    check("sat_r0", {32'd0, bus.dout_R_0}, 64'h7FFF_FFFF);
    check("sat_i0", {32'd0, bus.dout_I_0}, 64'h8000_0000);
    check("sat_r1", {32'd0, bus.dout_R_1}, 64'h7FFF_FFFF);
    check("sat_i1", {32'd0, bus.dout_I_1}, 64'h8000_0000);
    check("sat_cnt", {48'd0, sat_cnt}, 64'd2);
    bus.dout_ready = 1'b1;
    tick;
    check("sat_drain", {63'd0, bus.dout_valid}, 64'd0);

    // Skew error and clear
    lanes(1'b1, 64'd1, 1'b0, 64'd0);
    tick;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    tick;
    check("skew_set", {63'd0, skew_err}, 64'd1);
    check("skew_nopush", {61'd0, level}, 64'd0);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("skew_clr", {63'd0, skew_err}, 64'd0);
    check("skew_clr_sat", {48'd0, sat_cnt}, 64'd0);

    // Full / overflow: pairs 1..5 back-to-back with no consumer
    bus.dout_ready = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      lanes(c < 5, 64'(c + 1), c > 0, 64'(c));
      tick;
    end
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    check("ovf_level", {61'd0, level}, 64'd4);
    check("ovf_set", {63'd0, ovf_err}, 64'd1);
    check("ovf_noskew", {63'd0, skew_err}, 64'd0);
    bus.dout_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_pop%0d_valid", k), {63'd0, bus.dout_valid}, 64'd1);
      check($sformatf("ovf_pop%0d_r0", k), {32'd0, bus.dout_R_0}, 64'(k));
      check($sformatf("ovf_pop%0d_i1", k), {32'd0, bus.dout_I_1}, 64'(k));
      tick;
    end
    check("ovf_empty", {63'd0, bus.dout_valid}, 64'd0);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("ovf_clr", {63'd0, ovf_err}, 64'd0);

    // Full with simultaneous pop: pairs 5..8 buffered, then pair 9
    bus.dout_ready = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      lanes(c < 4, 64'(c + 5), c > 0, 64'(c + 4));
      tick;
    end
    check("fp_level_full", {61'd0, level}, 64'd4);
    lanes(1'b1, 64'd9, 1'b0, 64'd0);
    tick;
    lanes(1'b0, 64'd0, 1'b1, 64'd9);
    bus.dout_ready = 1'b1;
    check("fp_head", {32'd0, bus.dout_R_0}, 64'd5);
    tick;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    check("fp_level_hold", {61'd0, level}, 64'd4);
    check("fp_no_ovf", {63'd0, ovf_err}, 64'd0);
    for (int k = 6; k <= 9; k++) begin
      check($sformatf("fp_pop%0d", k), {32'd0, bus.dout_R_0}, 64'(k));
      check($sformatf("fp_pop%0d_i1", k), {32'd0, bus.dout_I_1}, 64'(k));
      tick;
    end
    check("fp_empty", {63'd0, bus.dout_valid}, 64'd0);

    // Saturation counter stops at 0xFFFF; clear loses to same-cycle increment
    for (int c = 0; c < 16400; c++) begin
      lanes(1'b1, HUGE, c > 0, HUGE);
      tick;
    end
    check("satcnt_stop", {48'd0, sat_cnt}, 64'hFFFF);
    check("satcnt_level", {61'd0, level}, 64'd1);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("satcnt_clr_inc", {48'd0, sat_cnt}, 64'd4);
    lanes(1'b0, 64'd0, 1'b1, HUGE);
    tick;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    check("satcnt_after", {48'd0, sat_cnt}, 64'd8);
    tick;
    check("satcnt_drain", {63'd0, bus.dout_valid}, 64'd0);
    check("satcnt_no_ovf", {63'd0, ovf_err}, 64'd0);

    // Reset mid-operation with 3 buffered pairs and a skew error
    bus.dout_ready = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      lanes(c < 3, 64'(c + 1), c > 0, 64'(c));
      tick;
    end
    lanes(1'b0, 64'd0, 1'b1, 64'd7);
    tick;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    check("mid_level", {61'd0, level}, 64'd3);
    check("mid_skew", {63'd0, skew_err}, 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_valid", {63'd0, bus.dout_valid}, 64'd0);
    check("mrst_level", {61'd0, level}, 64'd0);
    check("mrst_r0", {32'd0, bus.dout_R_0}, 64'd0);
    check("mrst_i1", {32'd0, bus.dout_I_1}, 64'd0);
    check("mrst_skew", {63'd0, skew_err}, 64'd0);
    check("mrst_ovf", {63'd0, ovf_err}, 64'd0);
    check("mrst_sat", {48'd0, sat_cnt}, 64'd0);
    lanes(1'b0, 64'd0, 1'b1, 64'd1);
    tick;
    lanes(1'b0, 64'd0, 1'b0, 64'd0);
    check("post_rst_skew", {63'd0, skew_err}, 64'd1);
    check("post_rst_level", {61'd0, level}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
